// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, acknowledge levels and the
// position of the R/W bit inside the address byte.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK
    } i2c_state_t;

    // Bus level of the acknowledge bit: ACK pulls SDA low, NACK leaves it high.
    localparam logic ACK_LVL  = 1'b0;
    localparam logic NACK_LVL = 1'b1;

    // R/W flag is the LSB of the address byte (1 = read).
    localparam int RW_BIT = 0;

endpackage

// File: rtl/i2c_sync_edge.sv
// Brings SCL/SDA into the clock domain and flags SCL edges, START and STOP.
module i2c_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl;
    logic                   scl_q;
    logic                   sda_q;

    // Synchronizer chains plus one history flop for edge detection; reset
    // to 1 so the bus looks idle and no false event fires after reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge value, which is what makes this a real shift chain.
            scl_sync <= (scl_sync << 1) | SYNC_STAGES'(scl_in);
            sda_sync <= (sda_sync << 1) | SYNC_STAGES'(sda_in);
            scl_q    <= scl;
            sda_q    <= sda;
        end
    end

    assign scl       = scl_sync[SYNC_STAGES-1];
    assign sda       = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl & ~scl_q;
    assign scl_fall  = ~scl & scl_q;
    // SDA may only toggle with SCL steadily high for a START/STOP.
    assign start_det = scl & scl_q & sda_q & ~sda;
    assign stop_det  = scl & scl_q & ~sda_q & sda;

endmodule

// File: rtl/i2c_sensor_slave.sv
// I2C target with an 8-bit register pointer: writes go to the register file
// with auto-increment, reads stream register data with auto-increment.
module i2c_sensor_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h48,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_wr_en,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    logic       sda, scl_rise, scl_fall, start_det, stop_det;
    i2c_state_t state, state_nxt;
    logic [2:0] bit_cnt, bit_cnt_nxt;
    logic [7:0] shift, shift_nxt;
    logic [7:0] rx_byte;
    logic [7:0] reg_addr_nxt, reg_wdata_nxt;
    logic       sda_oe_nxt, wr_en_nxt, busy_nxt;
    // Within an acknowledge state: 0 before the SCL fall that opens the ACK
    // bit, 1 once inside the ACK bit.
    logic       ack_slot, ack_slot_nxt;

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
        .clock     (clock),
        .reset_n   (reset_n),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    assign rx_byte = {shift[6:0], sda};

    // State and datapath registers; reset also releases SDA asynchronously.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            bit_cnt   <= 3'd0;
            shift     <= 8'h00;
            sda_oe    <= 1'b0;
            reg_addr  <= 8'h00;
            reg_wdata <= 8'h00;
            reg_wr_en <= 1'b0;
            busy      <= 1'b0;
            ack_slot  <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shift     <= shift_nxt;
            sda_oe    <= sda_oe_nxt;
            reg_addr  <= reg_addr_nxt;
            reg_wdata <= reg_wdata_nxt;
            reg_wr_en <= wr_en_nxt;
            busy      <= busy_nxt;
            ack_slot  <= ack_slot_nxt;
        end
    end

    // Next-state logic: START/STOP first, then SCL rising (sample) and
    // falling (drive) edges.
    always_comb begin
        // NOTE: every output gets a default before any branch, so no path
        // can leave one unassigned and infer a latch.
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        shift_nxt     = shift;
        sda_oe_nxt    = sda_oe;
        reg_addr_nxt  = reg_wr_en ? reg_addr + 8'd1 : reg_addr;
        reg_wdata_nxt = reg_wdata;
        wr_en_nxt     = 1'b0;
        busy_nxt      = busy;
        ack_slot_nxt  = ack_slot;

        if (start_det) begin
            state_nxt    = ST_ADDR;
            bit_cnt_nxt  = 3'd0;
            sda_oe_nxt   = 1'b0;
            ack_slot_nxt = 1'b0;
        end else if (stop_det) begin
            state_nxt    = ST_IDLE;
            bit_cnt_nxt  = 3'd0;
            sda_oe_nxt   = 1'b0;
            busy_nxt     = 1'b0;
            ack_slot_nxt = 1'b0;
        end else if (scl_rise) begin
            case (state)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    shift_nxt   = rx_byte;
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        ack_slot_nxt = 1'b0;
                        if (state == ST_ADDR) begin
                            if (rx_byte[7:1] == DEV_ADDR) begin
                                state_nxt = ST_ADDR_ACK;
                                busy_nxt  = 1'b1;
                            end else begin
                                state_nxt = ST_IDLE;
                                busy_nxt  = 1'b0;
                            end
                        end else if (state == ST_PTR) begin
                            reg_addr_nxt = rx_byte;
                            state_nxt    = ST_PTR_ACK;
                        end else begin
                            reg_wdata_nxt = rx_byte;
                            wr_en_nxt     = 1'b1;
                            state_nxt     = ST_WDATA_ACK;
                        end
                    end
                end
                ST_RDATA: begin
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_nxt    = ST_RDATA_ACK;
                        ack_slot_nxt = 1'b0;
                    end
                end
                ST_RDATA_ACK: begin
                    if (ack_slot) begin
                        if (sda == ACK_LVL) begin
                            reg_addr_nxt = reg_addr + 8'd1;
                        end else begin
                            state_nxt = ST_IDLE;
                            busy_nxt  = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end else if (scl_fall) begin
            case (state)
                ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (!ack_slot) begin
                        sda_oe_nxt   = ~ACK_LVL;
                        ack_slot_nxt = 1'b1;
                    end else begin
                        ack_slot_nxt = 1'b0;
                        bit_cnt_nxt  = 3'd0;
                        sda_oe_nxt   = 1'b0;
                        if (state == ST_ADDR_ACK && shift[RW_BIT]) begin
                            shift_nxt  = reg_rdata;
                            sda_oe_nxt = ~reg_rdata[7];
                            state_nxt  = ST_RDATA;
                        end else if (state == ST_ADDR_ACK) begin
                            state_nxt = ST_PTR;
                        end else begin
                            state_nxt = ST_WDATA;
                        end
                    end
                end
                ST_RDATA: begin
                    shift_nxt  = shift << 1;
                    sda_oe_nxt = ~shift[6];
                end
                ST_RDATA_ACK: begin
                    if (!ack_slot) begin
                        sda_oe_nxt   = 1'b0;
                        ack_slot_nxt = 1'b1;
                    end else begin
                        shift_nxt    = reg_rdata;
                        sda_oe_nxt   = ~reg_rdata[7];
                        ack_slot_nxt = 1'b0;
                        bit_cnt_nxt  = 3'd0;
                        state_nxt    = ST_RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_sensor_slave.sv
// Directed bench for i2c_sensor_slave: a bit-banged bus master plus a
// register-file write monitor, checked against hand-computed values.
module tb_i2c_sensor_slave;
    import i2c_pkg::*;

    localparam int Q = 40;  // quarter SCL period, 4 system clocks
    localparam int H = 80;  // half SCL period

    logic       clock = 1'b0;
    logic       reset_n;
    logic       scl;
    logic       sda_m;
    logic       sda_line;
    logic       sda_oe;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr_en;
    logic [7:0] reg_rdata;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] wr_addr_q[$];
    logic [7:0] wr_data_q[$];
    logic       oe_seen;
    logic       busy_seen;

    always #5 clock = ~clock;

    // Open-drain bus: either side can pull SDA low.
    assign sda_line  = sda_m & ~sda_oe;
    // Register file returns the inverted address.
    assign reg_rdata = reg_addr ^ 8'hFF;

    i2c_sensor_slave #(.DEV_ADDR(7'h48), .SYNC_STAGES(2)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .scl_in    (scl),
        .sda_in    (sda_line),
        .sda_oe    (sda_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_wr_en (reg_wr_en),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    // Record every write strobe cycle and whether SDA/busy were ever asserted.
    always @(negedge clock) begin
        if (reg_wr_en) begin
            wr_addr_q.push_back(reg_addr);
            wr_data_q.push_back(reg_wdata);
        end
        if (sda_oe) oe_seen <= 1'b1;
        if (busy) busy_seen <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        oe_seen   = 1'b0;
        busy_seen = 1'b0;
    endtask

    task automatic bus_start();
        sda_m = 1'b1; #Q;
        scl   = 1'b1; #H;
        sda_m = 1'b0; #H;
        scl   = 1'b0; #Q;
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; #Q;
        scl   = 1'b1; #H;
        sda_m = 1'b1; #H;
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            sda_m = b[7-i]; #Q;
            scl   = 1'b1;   #H;
            scl   = 1'b0;   #Q;
        end
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        send_bits(b, 8);
        sda_m = 1'b1; #Q;
        scl   = 1'b1; #Q;
        ack   = sda_line; #Q;
        scl   = 1'b0; #Q;
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d);
        for (int i = 0; i < 8; i++) begin
            sda_m = 1'b1; #Q;
            scl   = 1'b1; #Q;
            d[7-i] = sda_line; #Q;
            scl   = 1'b0; #Q;
        end
        sda_m = ack;  #Q;
        scl   = 1'b1; #H;
        scl   = 1'b0; #Q;
    endtask

    initial begin
        logic       a;
        logic [7:0] d;

        reset_n = 1'b0;
        scl     = 1'b1;
        sda_m   = 1'b1;
        clear_mon();
        repeat (3) @(negedge clock);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_reg_addr", reg_addr, 8'h00);
        check("rst_reg_wdata", reg_wdata, 8'h00);
        check("rst_wr_en", reg_wr_en, 0);
        check("rst_busy", busy, 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);

        // Write: pointer 05, data A5 and 3C.
        clear_mon();
        bus_start();
        write_byte(8'h90, a); check("wr_addr_ack", a, 0);
        check("wr_busy", busy, 1);
        write_byte(8'h05, a); check("wr_ptr_ack", a, 0);
        write_byte(8'hA5, a); check("wr_d0_ack", a, 0);
        write_byte(8'h3C, a); check("wr_d1_ack", a, 0);
        bus_stop();
        check("wr_count", wr_addr_q.size(), 2);
        check("wr0_addr", wr_addr_q[0], 8'h05);
        check("wr0_data", wr_data_q[0], 8'hA5);
        check("wr1_addr", wr_addr_q[1], 8'h06);
        check("wr1_data", wr_data_q[1], 8'h3C);
        check("wr_busy_stop", busy, 0);
        check("wr_ptr_final", reg_addr, 8'h07);

        // Read: pointer 10, repeated START, two bytes (ACK then NACK).
        clear_mon();
        bus_start();
        write_byte(8'h90, a); check("rd_waddr_ack", a, 0);
        write_byte(8'h10, a); check("rd_ptr_ack", a, 0);
        bus_start();
        write_byte(8'h91, a); check("rd_raddr_ack", a, 0);
        read_byte(ACK_LVL, d);  check("rd_byte0", d, 8'hEF);
        read_byte(NACK_LVL, d); check("rd_byte1", d, 8'hEE);
        check("rd_busy_nack", busy, 0);
        bus_stop();
        check("rd_no_write", wr_addr_q.size(), 0);
        check("rd_ptr_final", reg_addr, 8'h11);

        // Address miss: 0x92 must be ignored entirely.
        clear_mon();
        bus_start();
        write_byte(8'h92, a); check("miss_addr_nack", a, 1);
        write_byte(8'h05, a); check("miss_data_nack", a, 1);
        bus_stop();
        check("miss_oe_seen", oe_seen, 0);
        check("miss_no_write", wr_addr_q.size(), 0);
        check("miss_busy_seen", busy_seen, 0);

        // Pointer wrap: FF then 00.
        clear_mon();
        bus_start();
        write_byte(8'h90, a); check("wrap_addr_ack", a, 0);
        write_byte(8'hFF, a); check("wrap_ptr_ack", a, 0);
        write_byte(8'h11, a); check("wrap_d0_ack", a, 0);
        write_byte(8'h22, a); check("wrap_d1_ack", a, 0);
        bus_stop();
        check("wrap_count", wr_addr_q.size(), 2);
        check("wrap0_addr", wr_addr_q[0], 8'hFF);
        check("wrap0_data", wr_data_q[0], 8'h11);
        check("wrap1_addr", wr_addr_q[1], 8'h00);
        check("wrap1_data", wr_data_q[1], 8'h22);
        check("wrap_ptr_final", reg_addr, 8'h01);

        // Abort: STOP after 4 data bits.
        clear_mon();
        bus_start();
        write_byte(8'h90, a); check("abort_addr_ack", a, 0);
        write_byte(8'h07, a); check("abort_ptr_ack", a, 0);
        send_bits(8'hF0, 4);
        bus_stop();
        check("abort_no_write", wr_addr_q.size(), 0);
        check("abort_state", dut.state, ST_IDLE);
        check("abort_busy", busy, 0);
        check("abort_ptr", reg_addr, 8'h07);

        // Reset while the address ACK is being driven.
        bus_start();
        send_bits(8'h90, 8);
        sda_m = 1'b1; #Q;
        check("rst_ack_driven", sda_oe, 1);
        reset_n = 1'b0; #1;
        check("rst_async_release", sda_oe, 0);
        #9;
        reset_n = 1'b1;
        clear_mon();
        scl = 1'b1; #H;
        scl = 1'b0; #Q;
        check("rst_state", dut.state, ST_IDLE);
        check("rst_oe_after", oe_seen, 0);
        check("rst_busy_after", busy, 0);
        bus_stop();
        bus_start();
        write_byte(8'h90, a); check("rst_recover_ack", a, 0);
        bus_stop();
        check("rst_recover_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
